byte_gearbox_fifo: RTL and testbench

- Byte-granular ring buffer.
- Write side: variable-size writes of 1, 2, 4 … WR_BYTES bytes per beat.
- Read side: fixed RD_BYTES words through a registered valid/ready output stage.
- Flush mode drains a final partial word with a byte count.
- Exact occupancy tracking gives true full/empty.
- Sits between variable-width producers (packet/byte streams) and fixed-width consumers; parametrised successor of the lab byte FIFO.

---
 rtl/byte_fifo_pkg.sv | 44 ++++
 rtl/byte_gearbox_fifo_if.sv | 40 ++++
 rtl/byte_ring_mem.sv | 46 ++++
 rtl/byte_gearbox_fifo.sv | 167 ++++++++++++++++
 tb/tb_byte_gearbox_fifo.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_fifo_pkg.sv
// -----------------------------------------------------------------------------
// byte_fifo_pkg
// Shared types, default sizes and helper functions for the byte gearbox FIFO.
//   clog2       : ceiling log2 usable in constant expressions
//   size_bytes  : bytes carried by a write beat of a given in_size (1 << size)
//   size_legal  : true when a beat of that size fits in WR_BYTES lanes
//   load_kind_e : what the output register takes on a given cycle
// -----------------------------------------------------------------------------
package byte_fifo_pkg;

   localparam int DEF_DEPTH_BYTES = 256;
   localparam int DEF_WR_BYTES    = 8;
   localparam int DEF_RD_BYTES    = 4;
   localparam int DEF_SIZE_W      = 2;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Derived widths for the default configuration.
   localparam int DEF_PTR_W = clog2(DEF_DEPTH_BYTES);
   localparam int DEF_LVL_W = DEF_PTR_W + 1;

   function automatic int size_bytes(input int size);
      return 1 << size;
   endfunction

   // Sizes of 31 and up would overflow the shift, so they are illegal outright.
   function automatic bit size_legal(input int size, input int wr_bytes);
      return (size < 31) && ((1 << size) <= wr_bytes);
   endfunction

   typedef enum logic [1:0] {
      LOAD_NONE,
      LOAD_FULL,
      LOAD_PART
   } load_kind_e;

endpackage

// File: rtl/byte_gearbox_fifo_if.sv
// -----------------------------------------------------------------------------
// byte_gearbox_fifo_if
// Write-beat and output-word handshake bundle of the byte gearbox FIFO.
//   in_valid/in_size/in_data/in_ready : variable-size write beats
//   flush                             : one-cycle request to drain residue
//   out_valid/out_ready/out_data/out_bytes : fixed-width output words
// Modports:
//   master : the environment (producer and consumer)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface byte_gearbox_fifo_if
   import byte_fifo_pkg::*;
#(
   parameter int WR_BYTES = DEF_WR_BYTES,
   parameter int RD_BYTES = DEF_RD_BYTES,
   parameter int SIZE_W   = DEF_SIZE_W,
   parameter int OB_W     = clog2(RD_BYTES) + 1
);

   logic                  in_valid;
   logic [SIZE_W-1:0]     in_size;
   logic [8*WR_BYTES-1:0] in_data;
   logic                  in_ready;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*RD_BYTES-1:0] out_data;
   logic [OB_W-1:0]       out_bytes;

   modport master (
      output in_valid, in_size, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_bytes
   );

   modport slave (
      input  in_valid, in_size, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_bytes
   );

endinterface

// File: rtl/byte_ring_mem.sv
// -----------------------------------------------------------------------------
// byte_ring_mem
// DEPTH_BYTES x 8 ring storage.
//   clock   : write clock
//   wr_ptr  : byte address of write lane 0; lane i lands at wr_ptr+i (wraps)
//   wr_en   : per-lane write enable
//   wr_data : lane i is wr_data[8*i +: 8]
//   rd_ptr  : byte address of read lane 0; lane i reads rd_ptr+i (wraps)
//   rd_data : combinational read, lane i is rd_data[8*i +: 8]
// -----------------------------------------------------------------------------
module byte_ring_mem
   import byte_fifo_pkg::*;
#(
   parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
   parameter int WR_BYTES    = DEF_WR_BYTES,
   parameter int RD_BYTES    = DEF_RD_BYTES,
   parameter int PTR_W       = clog2(DEPTH_BYTES)
) (
   input  logic                  clock,
   input  logic [PTR_W-1:0]      wr_ptr,
   input  logic [WR_BYTES-1:0]   wr_en,
   input  logic [8*WR_BYTES-1:0] wr_data,
   input  logic [PTR_W-1:0]      rd_ptr,
   output logic [8*RD_BYTES-1:0] rd_data
);

   logic [7:0] mem [DEPTH_BYTES];

   // NOTE: the storage array has no reset; validity of its contents is tracked
   // by the pointers and level in the parent, so clearing it would buy nothing.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      for (int i = 0; i < WR_BYTES; i++) begin
         if (wr_en[i]) begin
            // PTR_W-bit sum wraps modulo DEPTH_BYTES on its own.
            mem[wr_ptr + PTR_W'(i)] <= wr_data[8*i +: 8];
         end
      end
   end

   for (genvar g = 0; g < RD_BYTES; g++) begin : g_rd_lane
      assign rd_data[8*g +: 8] = mem[rd_ptr + PTR_W'(g)];
   end

endmodule

// File: rtl/byte_gearbox_fifo.sv
// -----------------------------------------------------------------------------
// byte_gearbox_fifo
// Byte-granular ring FIFO: variable-size write beats in, fixed RD_BYTES words
// out through a registered valid/ready stage, with a flush that drains a
// final partial word.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : byte_gearbox_fifo_if.slave (write beats, flush, output words)
//   level    : bytes held in the ring, not counting the output register
//   err_size : sticky flag, an accepted beat carried an illegal in_size
// -----------------------------------------------------------------------------
module byte_gearbox_fifo
   import byte_fifo_pkg::*;
#(
   parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
   parameter int WR_BYTES    = DEF_WR_BYTES,
   parameter int RD_BYTES    = DEF_RD_BYTES,
   parameter int SIZE_W      = DEF_SIZE_W,
   parameter int LVL_W       = clog2(DEPTH_BYTES) + 1
) (
   input  logic             clock,
   input  logic             reset,
   byte_gearbox_fifo_if.slave bus,
   output logic [LVL_W-1:0] level,
   output logic             err_size
);

   localparam int PTR_W = clog2(DEPTH_BYTES);
   localparam int OB_W  = clog2(RD_BYTES) + 1;

   // A full WR_BYTES beat fits while level <= DEPTH_BYTES - WR_BYTES.
   localparam logic [LVL_W-1:0] ROOM_LIMIT = LVL_W'(DEPTH_BYTES - WR_BYTES);
   localparam logic [LVL_W-1:0] RD_LVL     = LVL_W'(RD_BYTES);

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  flush_pending;
   logic                  out_valid_q;
   logic [8*RD_BYTES-1:0] out_data_q;
   logic [OB_W-1:0]       out_bytes_q;

   logic                  in_ready_int;
   logic                  accept;
   logic                  size_ok;
   logic                  wr_fire;
   int                    wr_count;
   logic [WR_BYTES-1:0]   wr_lane_en;
   logic [LVL_W-1:0]      n_wr;
   logic [LVL_W-1:0]      n_rd;
   logic [LVL_W-1:0]      level_next;
   load_kind_e            load_kind;
   logic [OB_W-1:0]       load_bytes;
   logic [8*RD_BYTES-1:0] rd_word;
   logic [8*RD_BYTES-1:0] load_word;

   // in_ready depends only on registers, never on in_valid.
   assign in_ready_int  = !flush_pending && (level <= ROOM_LIMIT);
   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_bytes = out_bytes_q;

   // NOTE: every variable written here gets a default at the top of the
   // block, so no path can leave one unassigned and infer a latch.
   always_comb begin
      accept     = bus.in_valid && in_ready_int;
      size_ok    = size_legal(int'(bus.in_size), WR_BYTES);
      wr_fire    = accept && size_ok && !reset;
      wr_count   = size_bytes(int'(bus.in_size));
      n_wr       = '0;
      wr_lane_en = '0;
      if (wr_fire) begin
         n_wr = LVL_W'(wr_count);
         for (int i = 0; i < WR_BYTES; i++) begin
            wr_lane_en[i] = (i < wr_count);
         end
      end

      // The output register refills when empty or being emptied this cycle.
      // Full words take priority; a partial word only leaves under flush.
      load_kind = LOAD_NONE;
      if (!out_valid_q || bus.out_ready) begin
         if (level >= RD_LVL) begin
            load_kind = LOAD_FULL;
         end else if (flush_pending && (level != '0)) begin
            load_kind = LOAD_PART;
         end
      end

      n_rd       = '0;
      load_bytes = '0;
      case (load_kind)
         LOAD_FULL: begin
            n_rd       = RD_LVL;
            load_bytes = OB_W'(RD_BYTES);
         end
         LOAD_PART: begin
            n_rd       = level;
            load_bytes = OB_W'(level);
         end
         default: begin
            n_rd       = '0;
            load_bytes = '0;
         end
      endcase

      // Lanes beyond the loaded count are zeroed rather than carrying stale
      // ring contents.
      load_word = '0;
      for (int i = 0; i < RD_BYTES; i++) begin
         if (LVL_W'(i) < n_rd) begin
            load_word[8*i +: 8] = rd_word[8*i +: 8];
         end
      end

      // in_ready guarantees level + n_wr <= DEPTH_BYTES, so no overflow.
      level_next = level + n_wr - n_rd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         flush_pending <= 1'b0;
         err_size      <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_bytes_q   <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_wr);
         rd_ptr <= rd_ptr + PTR_W'(n_rd);
         level  <= level_next;

         // Pending persists until the ring is empty; a flush that finds the
         // ring already empty (and no write landing) never becomes pending.
         flush_pending <= (flush_pending || bus.flush) && (level_next != '0);

         if (accept && !size_ok) begin
            err_size <= 1'b1;
         end

         if (load_kind != LOAD_NONE) begin
            out_valid_q <= 1'b1;
            out_data_q  <= load_word;
            out_bytes_q <= load_bytes;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   byte_ring_mem #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .WR_BYTES    (WR_BYTES),
      .RD_BYTES    (RD_BYTES),
      .PTR_W       (PTR_W)
   ) u_mem (
      .clock   (clock),
      .wr_ptr  (wr_ptr),
      .wr_en   (wr_lane_en),
      .wr_data (bus.in_data),
      .rd_ptr  (rd_ptr),
      .rd_data (rd_word)
   );

endmodule

// File: tb/tb_byte_gearbox_fifo.sv
// -----------------------------------------------------------------------------
// tb_byte_gearbox_fifo
// Self-checking bench: a vector table for the basic and flush cases, hand
// sequences for fill/back-pressure and reset, a queue-based reference model
// under random traffic, and a WR_BYTES=4 instance for the illegal-size flag.
// -----------------------------------------------------------------------------
module tb_byte_gearbox_fifo;

   logic       clock = 1'b0;
   logic       reset;
   logic       reset4;
   logic [8:0] level;
   logic       err_size;
   logic [8:0] level4;
   logic       err4;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   byte_gearbox_fifo_if #(.WR_BYTES(8), .RD_BYTES(4), .SIZE_W(2)) bus ();
   byte_gearbox_fifo_if #(.WR_BYTES(4), .RD_BYTES(4), .SIZE_W(2)) bus4 ();

   byte_gearbox_fifo #(
      .DEPTH_BYTES (256),
      .WR_BYTES    (8),
      .RD_BYTES    (4),
      .SIZE_W      (2)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .level    (level),
      .err_size (err_size)
   );

   byte_gearbox_fifo #(
      .DEPTH_BYTES (256),
      .WR_BYTES    (4),
      .RD_BYTES    (4),
      .SIZE_W      (2)
   ) dut4 (
      .clock    (clock),
      .reset    (reset4),
      .bus      (bus4),
      .level    (level4),
      .err_size (err4)
   );

   typedef struct {
      logic        in_valid;
      logic [1:0]  in_size;
      logic [63:0] in_data;
      logic        flush;
      logic        out_ready;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [2:0]  exp_bytes;
      logic [8:0]  exp_level;
      logic        exp_in_ready;
   } vec_t;

   vec_t vecs [24];

   // Reference model state: ring contents as a plain byte queue.
   logic [7:0]  m_q [$];
   logic        m_ov;
   logic [31:0] m_data;
   logic [2:0]  m_bytes;
   logic        m_pend;
   logic [7:0]  next_byte;

   task automatic check(input string name, input logic [63:0] actual,
                        input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_size   = '0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   // One random-traffic cycle: predict, apply, compare.
   task automatic rnd_cycle(input logic v, input logic [1:0] sz,
                            input logic ordy, input logic fl);
      logic [63:0] d;
      logic        m_rdy;
      int          n_take;
      int          n_in;
      n_in  = 1 << sz;
      m_rdy = !m_pend && ((256 - m_q.size()) >= 8);
      check("rnd_in_ready", {63'd0, bus.in_ready}, {63'd0, m_rdy});
      for (int i = 0; i < 8; i++) begin
         d[8*i +: 8] = next_byte + 8'(i);
      end
      bus.in_valid  = v;
      bus.in_size   = sz;
      bus.in_data   = d;
      bus.flush     = fl;
      bus.out_ready = ordy;

      n_take = 0;
      if (!m_ov || ordy) begin
         if (m_q.size() >= 4) n_take = 4;
         else if (m_pend && m_q.size() > 0) n_take = m_q.size();
      end
      if (n_take > 0) begin
         m_data = '0;
         for (int i = 0; i < n_take; i++) begin
            m_data[8*i +: 8] = m_q.pop_front();
         end
         m_bytes = 3'(n_take);
         m_ov    = 1'b1;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      if (v && m_rdy) begin
         for (int i = 0; i < n_in; i++) begin
            m_q.push_back(next_byte + 8'(i));
         end
         next_byte = next_byte + 8'(n_in);
      end
      m_pend = (m_pend || fl) && (m_q.size() != 0);

      step();
      bus.flush = 1'b0;
      check("rnd_out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
      check("rnd_out_data",  {32'd0, bus.out_data},  {32'd0, m_data});
      check("rnd_out_bytes", {61'd0, bus.out_bytes}, {61'd0, m_bytes});
      check("rnd_level",     {55'd0, level},         64'(m_q.size()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepts;

      //               vld sz  data                    fl  ordy  ov  data          by  lvl  rdy
      vecs[0]  = '{1'b1, 2'd0, 64'hAA,                1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 9'd1, 1'b1};
      vecs[1]  = '{1'b1, 2'd0, 64'hBB,                1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 9'd2, 1'b1};
      vecs[2]  = '{1'b1, 2'd0, 64'hCC,                1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 9'd3, 1'b1};
      vecs[3]  = '{1'b1, 2'd0, 64'hDD,                1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 9'd4, 1'b1};
      vecs[4]  = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b1, 32'hDDCCBBAA, 3'd4, 9'd0, 1'b1};
      vecs[5]  = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b0, 32'hDDCCBBAA, 3'd4, 9'd0, 1'b1};
      vecs[6]  = '{1'b1, 2'd3, 64'h0706050403020100,  1'b0, 1'b1, 1'b0, 32'hDDCCBBAA, 3'd4, 9'd8, 1'b1};
      vecs[7]  = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b1, 32'h03020100, 3'd4, 9'd4, 1'b1};
      vecs[8]  = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b1, 32'h07060504, 3'd4, 9'd0, 1'b1};
      vecs[9]  = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b0, 32'h07060504, 3'd4, 9'd0, 1'b1};
      vecs[10] = '{1'b1, 2'd0, 64'h11,                1'b0, 1'b1, 1'b0, 32'h07060504, 3'd4, 9'd1, 1'b1};
      vecs[11] = '{1'b1, 2'd0, 64'h22,                1'b0, 1'b1, 1'b0, 32'h07060504, 3'd4, 9'd2, 1'b1};
      vecs[12] = '{1'b1, 2'd0, 64'h33,                1'b0, 1'b1, 1'b0, 32'h07060504, 3'd4, 9'd3, 1'b1};
      vecs[13] = '{1'b0, 2'd0, 64'h0,                 1'b1, 1'b1, 1'b0, 32'h07060504, 3'd4, 9'd3, 1'b0};
      vecs[14] = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b1, 32'h00332211, 3'd3, 9'd0, 1'b1};
      vecs[15] = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b0, 32'h00332211, 3'd3, 9'd0, 1'b1};
      vecs[16] = '{1'b0, 2'd0, 64'h0,                 1'b1, 1'b1, 1'b0, 32'h00332211, 3'd3, 9'd0, 1'b1};
      vecs[17] = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b0, 32'h00332211, 3'd3, 9'd0, 1'b1};
      vecs[18] = '{1'b1, 2'd2, 64'hDEADBEEF_A3A2A1A0, 1'b0, 1'b0, 1'b0, 32'h00332211, 3'd3, 9'd4, 1'b1};
      vecs[19] = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 3'd4, 9'd0, 1'b1};
      vecs[20] = '{1'b1, 2'd1, 64'hFFFFFFFF_FFFFB1B0, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 3'd4, 9'd2, 1'b1};
      vecs[21] = '{1'b1, 2'd1, 64'hFFFFFFFF_FFFFB3B2, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 3'd4, 9'd4, 1'b1};
      vecs[22] = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b1, 32'hB3B2B1B0, 3'd4, 9'd0, 1'b1};
      vecs[23] = '{1'b0, 2'd0, 64'h0,                 1'b0, 1'b1, 1'b0, 32'hB3B2B1B0, 3'd4, 9'd0, 1'b1};

      // ---- reset ----
      idle();
      bus4.in_valid  = 1'b0;
      bus4.in_size   = '0;
      bus4.in_data   = '0;
      bus4.flush     = 1'b0;
      bus4.out_ready = 1'b0;
      reset  = 1'b1;
      reset4 = 1'b1;
      step();
      step();
      reset  = 1'b0;
      reset4 = 1'b0;
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_out_data",  {32'd0, bus.out_data},  64'd0);
      check("rst_out_bytes", {61'd0, bus.out_bytes}, 64'd0);
      check("rst_level",     {55'd0, level},         64'd0);
      check("rst_err_size",  {63'd0, err_size},      64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);

      // ---- vector table ----
      for (int k = 0; k < 24; k++) begin
         bus.in_valid  = vecs[k].in_valid;
         bus.in_size   = vecs[k].in_size;
         bus.in_data   = vecs[k].in_data;
         bus.flush     = vecs[k].flush;
         bus.out_ready = vecs[k].out_ready;
         step();
         check($sformatf("vec%0d_out_valid", k), {63'd0, bus.out_valid}, {63'd0, vecs[k].exp_valid});
         check($sformatf("vec%0d_out_data", k),  {32'd0, bus.out_data},  {32'd0, vecs[k].exp_data});
         check($sformatf("vec%0d_out_bytes", k), {61'd0, bus.out_bytes}, {61'd0, vecs[k].exp_bytes});
         check($sformatf("vec%0d_level", k),     {55'd0, level},         {55'd0, vecs[k].exp_level});
         check($sformatf("vec%0d_in_ready", k),  {63'd0, bus.in_ready},  {63'd0, vecs[k].exp_in_ready});
      end
      idle();

      // ---- fill under back-pressure ----
      accepts = 0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_size   = 2'd3;
      for (int c = 0; c < 40; c++) begin
         if (!bus.in_ready) break;
         for (int i = 0; i < 8; i++) begin
            bus.in_data[8*i +: 8] = 8'(8 * accepts + i);
         end
         accepts++;
         step();
      end
      check("fill_accepts",  64'(accepts),          64'd32);
      check("fill_level",    {55'd0, level},        64'd252);
      check("fill_in_ready", {63'd0, bus.in_ready}, 64'd0);
      step();
      check("fill_ignored_level", {55'd0, level},         64'd252);
      check("fill_out_valid",     {63'd0, bus.out_valid}, 64'd1);
      check("fill_out_data",      {32'd0, bus.out_data},  64'h03020100);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("pulse_level",    {55'd0, level},        64'd248);
      check("pulse_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("pulse_out_data", {32'd0, bus.out_data}, 64'h07060504);

      // ---- reset mid-stream ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_rst_out_data",  {32'd0, bus.out_data},  64'd0);
      check("mid_rst_out_bytes", {61'd0, bus.out_bytes}, 64'd0);
      check("mid_rst_level",     {55'd0, level},         64'd0);
      check("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd1);

      // ---- random traffic against the queue model ----
      idle();
      m_q.delete();
      m_ov      = 1'b0;
      m_data    = '0;
      m_bytes   = '0;
      m_pend    = 1'b0;
      next_byte = 8'h00;
      for (int c = 0; c < 200; c++) begin
         rnd_cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
      end
      rnd_cycle(1'b0, 2'd0, 1'b1, 1'b1);
      for (int c = 0; c < 80; c++) begin
         rnd_cycle(1'b0, 2'd0, 1'b1, 1'b0);
      end
      check("drain_level",     {55'd0, level},         64'd0);
      check("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);

      // ---- illegal size on the WR_BYTES=4 instance ----
      bus4.in_valid = 1'b1;
      bus4.in_size  = 2'd3;
      bus4.in_data  = 32'h44332211;
      step();
      check("ill_level", {55'd0, level4}, 64'd0);
      check("ill_err",   {63'd0, err4},   64'd1);
      bus4.in_size = 2'd2;
      for (int k = 0; k < 6; k++) begin
         bus4.in_data = 32'h10101010 * 32'(k + 1);
         step();
      end
      bus4.in_valid = 1'b0;
      check("w4_level",     {55'd0, level4},         64'd20);
      check("w4_out_valid", {63'd0, bus4.out_valid}, 64'd1);
      check("w4_out_data",  {32'd0, bus4.out_data},  64'h10101010);
      check("w4_err_sticky", {63'd0, err4},          64'd1);
      step();
      check("w4_err_hold", {63'd0, err4}, 64'd1);
      reset4 = 1'b1;
      step();
      reset4 = 1'b0;
      check("w4_rst_out_valid", {63'd0, bus4.out_valid}, 64'd0);
      check("w4_rst_out_data",  {32'd0, bus4.out_data},  64'd0);
      check("w4_rst_out_bytes", {61'd0, bus4.out_bytes}, 64'd0);
      check("w4_rst_level",     {55'd0, level4},         64'd0);
      check("w4_rst_err",       {63'd0, err4},           64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
